data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_pkg.sv | 59 +++++
 rtl/lfsr32.sv | 35 +++
 rtl/data_bus_responder.sv | 112 +++++++++++
 tb/tb_data_bus_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_bus_pkg                                                         |
// | Address map, RAM geometry and LFSR constants for data_bus_responder. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package data_bus_pkg;

    localparam int unsigned c_ram_depth = 256;
    localparam logic [31:0] c_ram_base  = 32'h0000_0000;
    localparam logic [31:0] c_ram_bytes = 32'(c_ram_depth * 4);
    localparam logic [31:0] c_reg_base  = 32'h0000_1000;

    localparam logic [31:0] c_off_led   = 32'h00;
    localparam logic [31:0] c_off_sw    = 32'h04;
    localparam logic [31:0] c_off_rand  = 32'h08;
    localparam logic [31:0] c_off_timer = 32'h0C;
    localparam logic [31:0] c_off_btn   = 32'h10;
    localparam logic [31:0] c_off_err   = 32'h14;

    localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;
    localparam logic [31:0] c_lfsr_seed = 32'h0000_0001;
    // Bit 0 of the mask names the output tap itself; it is not folded back in.
    localparam logic [31:0] c_lfsr_taps = c_lfsr_mask & ~32'h1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_RAND,
        SEL_TIMER,
        SEL_BTN,
        SEL_ERR,
        SEL_NONE
    } sel_e;

    function automatic sel_e decode_addr(input logic [29:0] wa);
        logic [31:0] addr;
        sel_e        sel;
        addr = {wa, 2'b00};
        sel  = SEL_NONE;
        if ((addr - c_ram_base) < c_ram_bytes) begin
            sel = SEL_RAM;
        end else begin
            case (addr - c_reg_base)
                c_off_led:   sel = SEL_LED;
                c_off_sw:    sel = SEL_SW;
                c_off_rand:  sel = SEL_RAND;
                c_off_timer: sel = SEL_TIMER;
                c_off_btn:   sel = SEL_BTN;
                c_off_err:   sel = SEL_ERR;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr32                                                               |
// | Free-running right-shift Galois LFSR with reseed and lockup guard.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lfsr32
    import data_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= c_lfsr_seed;
        end else if (load) begin
            // An all-zero state would never leave zero.
            r_q <= (seed == 32'h0) ? c_lfsr_seed : seed;
        end else if (r_q[0]) begin
            r_q <= (r_q >> 1) ^ c_lfsr_taps;
        end else begin
            r_q <= r_q >> 1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_bus_responder                                                   |
// | Word-addressed CPU bus slave: RAM, LEDs, switches, LFSR, timer, btn. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_bus_responder
    import data_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic [9:0]  sw,
    input  logic        btn,
    output logic [9:0]  leds,
    output logic        bus_err
);

    logic [31:0] r_ram [c_ram_depth];
    logic [9:0]  r_leds;
    logic [9:0]  r_sw_s1;
    logic [9:0]  r_sw_s2;
    logic        r_btn_s1;
    logic        r_btn_s2;
    logic        r_btn_d;
    logic        r_btn_evt;
    logic        r_bus_err;
    logic [31:0] r_timer;

    sel_e        w_sel;
    logic [31:0] w_rand;
    logic        w_btn_rise;
    logic        w_rand_load;
    logic        w_unused_addr;

    assign w_sel         = decode_addr(a[31:2]);
    assign w_btn_rise    = r_btn_s2 & ~r_btn_d;
    assign w_rand_load   = we & (w_sel == SEL_RAND);
    assign w_unused_addr = ^a[1:0];

    lfsr32 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_rand_load),
        .seed (wd),
        .q    (w_rand)
    );

    // RAM has no reset so its contents survive one.
    always_ff @(posedge clk) begin
        if (rst && we && (w_sel == SEL_RAM)) begin
            r_ram[a[9:2]] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_leds    <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_btn_d   <= 1'b0;
            r_btn_evt <= 1'b0;
            r_bus_err <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
            r_timer  <= r_timer + 32'd1;
            if (w_btn_rise) begin
                r_btn_evt <= 1'b1;
            end
            if (we) begin
                case (w_sel)
                    SEL_LED:   r_leds  <= wd[9:0];
                    SEL_TIMER: r_timer <= wd;
                    // A simultaneous new press wins over the clear.
                    SEL_BTN:   if (wd[0] && !w_btn_rise) r_btn_evt <= 1'b0;
                    SEL_ERR:   r_bus_err <= 1'b0;
                    SEL_NONE:  r_bus_err <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rd = '0;
        case (w_sel)
            SEL_RAM:   rd = r_ram[a[9:2]];
            SEL_LED:   rd = {22'b0, r_leds};
            SEL_SW:    rd = {22'b0, r_sw_s2};
            SEL_RAND:  rd = w_rand;
            SEL_TIMER: rd = r_timer;
            SEL_BTN:   rd = {31'b0, r_btn_evt};
            SEL_ERR:   rd = {31'b0, r_bus_err};
            default:   rd = '0;
        endcase
    end

    assign leds    = r_leds;
    assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_bus_responder                                                |
// | Self-checking bench with a behavioural reference model.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [9:0]  sw;
    logic        btn;
    logic [9:0]  leds;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_bus_responder dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .a       (a),
        .wd      (wd),
        .rd      (rd),
        .sw      (sw),
        .btn     (btn),
        .leds    (leds),
        .bus_err (bus_err)
    );

    // Reference model state
    logic [31:0] m_ram [256];
    logic [9:0]  m_leds;
    logic [31:0] m_rand;
    logic [31:0] m_timer;
    logic        m_evt;
    logic        m_err;
    logic [9:0]  m_sw_sync [2];
    logic        m_btn_sync [2];
    logic        m_btn_last;

    // Right shift; when a 1 falls out, the taps implied by 1 -> 0x80200002 are folded in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0002) : (v >> 1);
    endfunction

    function automatic int region(input logic [31:0] addr);
        logic [31:0] w;
        w = addr & ~32'h3;
        if (w < 32'h400) return 0;
        case (w)
            32'h1000: return 1;
            32'h1004: return 2;
            32'h1008: return 3;
            32'h100C: return 4;
            32'h1010: return 5;
            32'h1014: return 6;
            default:  return 7;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        case (region(addr))
            0:       return m_ram[addr[9:2]];
            1:       return {22'b0, m_leds};
            2:       return {22'b0, m_sw_sync[1]};
            3:       return m_rand;
            4:       return m_timer;
            5:       return {31'b0, m_evt};
            6:       return {31'b0, m_err};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge: advance the model with the inputs the DUT sees, then settle.
    task automatic step();
        logic rise;
        @(posedge clk);
        if (!rst) begin
            m_leds = '0; m_rand = 32'h1; m_timer = '0; m_evt = 1'b0; m_err = 1'b0;
            m_sw_sync[0] = '0; m_sw_sync[1] = '0;
            m_btn_sync[0] = 1'b0; m_btn_sync[1] = 1'b0; m_btn_last = 1'b0;
        end else begin
            rise          = m_btn_sync[1] && !m_btn_last;
            m_btn_last    = m_btn_sync[1];
            m_btn_sync[1] = m_btn_sync[0];
            m_btn_sync[0] = btn;
            m_sw_sync[1]  = m_sw_sync[0];
            m_sw_sync[0]  = sw;
            m_timer       = m_timer + 32'd1;
            m_rand        = lfsr_next(m_rand);
            if (rise) m_evt = 1'b1;
            if (we) begin
                case (region(a))
                    0: m_ram[a[9:2]] = wd;
                    1: m_leds = wd[9:0];
                    3: m_rand = (wd == 32'h0) ? 32'h1 : wd;
                    4: m_timer = wd;
                    5: if (wd[0] && !rise) m_evt = 1'b0;
                    6: m_err = 1'b0;
                    7: m_err = 1'b1;
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 1'b0; a = 32'h1008; wd = '0; sw = '0; btn = 1'b0;
        step(); step();
        checks++; if (leds !== 10'h0) begin failures++; $display("FAIL reset_leds got=%h want=000", leds); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus_err); end
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL reset_rand got=%h want=00000001", rd); end
        a = 32'h100C; #1;
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_timer got=%h want=00000000", rd); end
        rst = 1'b1;
    endtask

    task automatic test_ram();
        for (int i = 0; i < 256; i++) begin
            we = 1'b1; a = i * 4; wd = $urandom; step();
        end
        a = 32'h40; wd = 32'hDEAD_BEEF; step();
        we = 1'b0;
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_0x40 got=%h want=deadbeef", rd); end
        a = 32'h43; #1;
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_0x43 got=%h want=deadbeef", rd); end
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 32'h3FF); #1;
            checks++; if (rd !== m_read(a)) begin failures++; $display("FAIL ram_rand a=%h got=%h want=%h", a, rd, m_read(a)); end
        end
    endtask

    task automatic test_rand();
        logic [31:0] seed;
        we = 1'b1; a = 32'h1008; wd = 32'h0; step();
        we = 1'b0;
        checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL rand_seed0 got=%h want=00000001", rd); end
        step();
        checks++; if (rd !== 32'h8020_0002) begin failures++; $display("FAIL rand_step1 got=%h want=80200002", rd); end
        step();
        checks++; if (rd !== 32'h4010_0001) begin failures++; $display("FAIL rand_step2 got=%h want=40100001", rd); end
        seed = $urandom | 32'h1;
        we = 1'b1; wd = seed; step();
        we = 1'b0;
        checks++; if (rd !== seed) begin failures++; $display("FAIL rand_seed got=%h want=%h", rd, seed); end
        step();
        checks++; if (rd !== m_read(a)) begin failures++; $display("FAIL rand_next got=%h want=%h", rd, m_read(a)); end
    endtask

    task automatic test_timer();
        we = 1'b1; a = 32'h100C; wd = 32'hFFFF_FFFE; step();
        we = 1'b0;
        checks++; if (rd !== 32'hFFFF_FFFE) begin failures++; $display("FAIL timer_load got=%h want=fffffffe", rd); end
        step();
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL timer_max got=%h want=ffffffff", rd); end
        step();
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h want=00000000", rd); end
        we = 1'b1; wd = 32'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rd !== 32'd5) begin failures++; $display("FAIL timer_hold got=%h want=00000005", rd); end
        end
        we = 1'b0; step();
        checks++; if (rd !== 32'd6) begin failures++; $display("FAIL timer_resume got=%h want=00000006", rd); end
    endtask

    task automatic test_btn();
        btn = 1'b0; we = 1'b0; a = 32'h1010;
        step(); step(); step();
        we = 1'b1; wd = 32'h1; step();
        we = 1'b0;
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL btn_cleared got=%h want=0", rd); end
        btn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (rd !== ((i >= 3) ? 32'h1 : 32'h0)) begin
                failures++; $display("FAIL btn_press cyc=%0d got=%h want=%0d", i, rd, (i >= 3));
            end
        end
        btn = 1'b0;
        step(); step(); step();
        we = 1'b1; wd = 32'h1; step();
        we = 1'b0;
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL btn_clear got=%h want=0", rd); end
        btn = 1'b1; step(); step();
        we = 1'b1; wd = 32'h1; step();
        we = 1'b0;
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL btn_edge_vs_clear got=%h want=1", rd); end
        we = 1'b1; step();
        we = 1'b0; step(); step();
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL btn_one_event got=%h want=0", rd); end
        btn = 1'b0; step();
    endtask

    task automatic test_sw();
        logic [9:0] v;
        v = 10'($urandom_range(1, 1023));
        a = 32'h1004; we = 1'b0; sw = v; step();
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_lat1 got=%h want=0", rd); end
        step();
        checks++; if (rd !== {22'b0, v}) begin failures++; $display("FAIL sw_lat2 got=%h want=%h", rd, {22'b0, v}); end
    endtask

    task automatic test_err();
        we = 1'b1; a = 32'h2000; wd = 32'h1234; step();
        we = 1'b0;
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", bus_err); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_rd got=%h want=0", rd); end
        we = 1'b1; a = 32'h1014; wd = 32'h0; step();
        we = 1'b0;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", bus_err); end
        we = 1'b1; a = 32'h1004; wd = 32'hFFFF_FFFF; step();
        we = 1'b0;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL err_ro got=%b want=0", bus_err); end
        checks++; if (rd !== m_read(a)) begin failures++; $display("FAIL sw_ro got=%h want=%h", rd, m_read(a)); end
        we = 1'b1; a = 32'h1000; wd = 32'hABCD_E3FF; step();
        we = 1'b0;
        checks++; if (leds !== 10'h3FF) begin failures++; $display("FAIL led_write got=%h want=3ff", leds); end
        checks++; if (rd !== 32'h3FF) begin failures++; $display("FAIL led_read got=%h want=000003ff", rd); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [9];
        addrs = '{32'h0, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h2000, 32'h1018};
        for (int i = 0; i < 300; i++) begin
            int k;
            k   = $urandom_range(0, 8);
            a   = (k == 0) ? 32'($urandom_range(0, 32'h3FF)) : (addrs[k] | 32'($urandom_range(0, 3)));
            we  = ($urandom_range(0, 2) != 0);
            wd  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            sw  = 10'($urandom);
            if ($urandom_range(0, 3) == 0) btn = ~btn;
            step();
            checks++; if (rd !== m_read(a)) begin failures++; $display("FAIL rand_rd i=%0d a=%h got=%h want=%h", i, a, rd, m_read(a)); end
            checks++; if (leds !== m_leds) begin failures++; $display("FAIL rand_leds i=%0d got=%h want=%h", i, leds, m_leds); end
            checks++; if (bus_err !== m_err) begin failures++; $display("FAIL rand_err i=%0d got=%b want=%b", i, bus_err, m_err); end
        end
        we = 1'b0; btn = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] saved;
        saved = m_ram[16];
        we = 1'b1; a = 32'h1000; wd = 32'h155; step();
        a = 32'h2000; step();
        rst = 1'b0; a = 32'h40; wd = ~saved; step();
        we = 1'b0;
        checks++; if (leds !== 10'h0) begin failures++; $display("FAIL rst_leds got=%h want=000", leds); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", bus_err); end
        checks++; if (rd !== saved) begin failures++; $display("FAIL rst_ram got=%h want=%h", rd, saved); end
        a = 32'h100C; #1;
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_timer got=%h want=0", rd); end
        a = 32'h1008; #1;
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rst_rand got=%h want=1", rd); end
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ram();
        test_rand();
        test_timer();
        test_btn();
        test_sw();
        test_err();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
